bpsk_link_sequencer: RTL

- Central timing and measurement sequencer for the basic BPSK link: PRBS source -> BPSK mapper -> oversampled TX filter -> channel -> downsampler -> BER checker.
- Generates the symbol-rate valid strobe (one per OS clocks) that gates the PRBS and the mapper.
- Generates the downsampler sampling strobe at a programmable phase.
- Sequences a BER measurement run: clear, flush pipeline latency, measure N symbols, done.

---
 rtl/bpsk_link_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bpsk_link_sequencer.sv
// rtl/bpsk_link_sequencer.sv - symbol/sample strobe generator and BER measurement sequencer
module bpsk_link_sequencer #(
  parameter int OS     = 4,
  parameter int NB_CNT = 16,
  parameter int NB_PH  = 2
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [NB_PH-1:0]  i_phase,
  input  logic [NB_CNT-1:0] i_flush_len,
  input  logic [NB_CNT-1:0] i_meas_len,
  output logic              o_valid,
  output logic              o_sample_strobe,
  output logic              o_ber_clear,
  output logic              o_ber_enable,
  output logic              o_done,
  output logic              o_busy,
  output logic [1:0]        o_state,
  output logic [NB_CNT-1:0] o_sym_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [NB_PH-1:0] CNT_LAST = NB_PH'(OS - 1);

  state_t            state, next_state;
  logic [NB_PH-1:0]  cnt;
  logic [NB_CNT-1:0] flush_len, meas_len, sym_count, sym_next;
  logic              run, tick, enter_flush, leave_flush;
  logic              valid_d, strobe_d, clear_d, ber_en_d, done_d, busy_d;

  assign run         = ((state == FLUSH) || (state == MEASURE)) && i_enable;
  assign tick        = run && (cnt == CNT_LAST);
  assign sym_next    = sym_count + NB_CNT'(1);
  assign enter_flush = !i_stop && (next_state == FLUSH) && (state != FLUSH);
  assign leave_flush = !i_stop && (state == FLUSH) && (next_state == MEASURE);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (i_stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (i_start && i_enable) next_state = FLUSH;
        FLUSH: begin
          if ((flush_len == '0 && i_enable) || (tick && sym_next == flush_len))
            next_state = MEASURE;
        end
        MEASURE: begin
          // meas_len of zero means free-running; only i_stop leaves
          if (tick && meas_len != '0 && sym_next == meas_len)
            next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d  = tick && !i_stop;
    strobe_d = run && (cnt == i_phase) && !i_stop;
    clear_d  = enter_flush;
    ber_en_d = (state == MEASURE) && !i_stop;
    done_d   = (state == MEASURE) && (next_state == DONE);
    busy_d   = (next_state == FLUSH) || (next_state == MEASURE);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt       <= '0;
      sym_count <= '0;
      flush_len <= '0;
      meas_len  <= '0;
    end else begin
      if (i_stop || next_state == IDLE || enter_flush)
        cnt <= '0;
      else if (run)
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + NB_PH'(1);

      if (i_stop || enter_flush || leave_flush)
        sym_count <= '0;
      else if (tick)
        sym_count <= sym_next;

      if (enter_flush) begin
        flush_len <= i_flush_len;
        meas_len  <= i_meas_len;
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid         <= 1'b0;
      o_sample_strobe <= 1'b0;
      o_ber_clear     <= 1'b0;
      o_ber_enable    <= 1'b0;
      o_done          <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_valid         <= valid_d;
      o_sample_strobe <= strobe_d;
      o_ber_clear     <= clear_d;
      o_ber_enable    <= ber_en_d;
      o_done          <= done_d;
      o_busy          <= busy_d;
    end
  end

  assign o_state     = state;
  assign o_sym_count = sym_count;

endmodule
